// File: rtl/vga_scanout_reader.sv
// Frame buffer scanout: 640x480@60 VGA timing, raster-order pixel fetch, buffer swap at vblank start.
// Colour/sync appear RD_LATENCY+1 clk after the pixel's pix_en cycle; free-running, no backpressure.
module vga_scanout_reader #(
    parameter int   H_ACTIVE   = 640,
    parameter int   H_FP       = 16,
    parameter int   H_SYNC     = 96,
    parameter int   H_BP       = 48,
    parameter int   V_ACTIVE   = 480,
    parameter int   V_FP       = 10,
    parameter int   V_SYNC     = 2,
    parameter int   V_BP       = 33,
    parameter int   CLK_DIV    = 2,
    parameter int   RD_LATENCY = 1,
    parameter logic SYNC_POL   = 1'b0
) (
    input  logic        clk,
    input  logic        areset_n,
    output logic        rd_en,
    output logic [19:0] rd_addr,
    input  logic [3:0]  rd_data,
    input  logic        swap_req,
    output logic        swap_ack,
    output logic        buf_active,
    output logic        vblank,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_W     = $clog2(H_TOTAL);
    localparam int V_W     = $clog2(V_TOTAL);
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int OFF_W   = 19;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [H_W-1:0]   H_LAST   = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0]   H_ACT_L  = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0]   HS_BEG   = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0]   HS_END   = H_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [V_W-1:0]   V_LAST   = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0]   V_ACT_L  = V_W'(V_ACTIVE);
    localparam logic [V_W-1:0]   V_PRE    = V_W'(V_ACTIVE - 1);
    localparam logic [V_W-1:0]   VS_BEG   = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0]   VS_END   = V_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [DIV_W-1:0]      r_div_cnt;
    logic [H_W-1:0]        r_h_cnt;
    logic [V_W-1:0]        r_v_cnt;
    logic [OFF_W-1:0]      r_line_base;
    logic                  r_rd_en;
    logic [19:0]           r_rd_addr;
    logic                  r_swap_ack;
    logic                  r_buf_active;
    logic [RD_LATENCY:0]   r_pe_pipe;
    logic [RD_LATENCY:0]   r_act_pipe;
    logic [RD_LATENCY:0]   r_hs_pipe;
    logic [RD_LATENCY:0]   r_vs_pipe;
    logic [3:0]            r_pix;
    logic                  r_hs;
    logic                  r_vs;

    logic                  w_pix_en;
    logic                  w_h_wrap;
    logic                  w_v_wrap;
    logic                  w_active;
    logic                  w_hs;
    logic                  w_vs;
    logic                  w_vblank_start;
    logic [OFF_W-1:0]      w_offset;

    assign w_pix_en       = (r_div_cnt == DIV_LAST);
    assign w_h_wrap       = (r_h_cnt == H_LAST);
    assign w_v_wrap       = (r_v_cnt == V_LAST);
    assign w_active       = (r_h_cnt < H_ACT_L) && (r_v_cnt < V_ACT_L);
    assign w_hs           = (r_h_cnt >= HS_BEG && r_h_cnt <= HS_END) ? SYNC_POL : ~SYNC_POL;
    assign w_vs           = (r_v_cnt >= VS_BEG && r_v_cnt <= VS_END) ? SYNC_POL : ~SYNC_POL;
    // Last pix_en of the final visible line: counters move to (0, V_ACTIVE) on this edge.
    assign w_vblank_start = w_pix_en && w_h_wrap && (r_v_cnt == V_PRE);
    assign w_offset       = r_line_base + OFF_W'(r_h_cnt);

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_div_cnt   <= '0;
            r_h_cnt     <= '0;
            r_v_cnt     <= '0;
            r_line_base <= '0;
        end else begin
            r_div_cnt <= w_pix_en ? '0 : r_div_cnt + 1'b1;
            if (w_pix_en) begin
                if (w_h_wrap) begin
                    r_h_cnt <= '0;
                    if (w_v_wrap) begin
                        r_v_cnt     <= '0;
                        r_line_base <= '0;
                    end else begin
                        r_v_cnt <= r_v_cnt + 1'b1;
                        if (r_v_cnt < V_ACT_L)
                            r_line_base <= r_line_base + OFF_W'(H_ACTIVE);
                    end
                end else begin
                    r_h_cnt <= r_h_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_rd_en      <= 1'b0;
            r_rd_addr    <= '0;
            r_swap_ack   <= 1'b0;
            r_buf_active <= 1'b0;
        end else begin
            r_rd_en    <= w_pix_en && w_active;
            r_swap_ack <= w_vblank_start && swap_req;
            if (w_pix_en && w_active)
                r_rd_addr <= {r_buf_active, w_offset};
            if (w_vblank_start && swap_req)
                r_buf_active <= ~r_buf_active;
        end
    end

    // Timing flags ride alongside the RAM read so they land with their pixel's data.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_pe_pipe  <= '0;
            r_act_pipe <= '0;
            r_hs_pipe  <= '0;
            r_vs_pipe  <= '0;
            r_pix      <= 4'h0;
            r_hs       <= ~SYNC_POL;
            r_vs       <= ~SYNC_POL;
        end else begin
            r_pe_pipe  <= {r_pe_pipe[RD_LATENCY-1:0],  w_pix_en};
            r_act_pipe <= {r_act_pipe[RD_LATENCY-1:0], w_active};
            r_hs_pipe  <= {r_hs_pipe[RD_LATENCY-1:0],  w_hs};
            r_vs_pipe  <= {r_vs_pipe[RD_LATENCY-1:0],  w_vs};
            if (r_pe_pipe[RD_LATENCY]) begin
                r_pix <= r_act_pipe[RD_LATENCY] ? rd_data : 4'h0;
                r_hs  <= r_hs_pipe[RD_LATENCY];
                r_vs  <= r_vs_pipe[RD_LATENCY];
            end
        end
    end

    assign rd_en      = r_rd_en;
    assign rd_addr    = r_rd_addr;
    assign swap_ack   = r_swap_ack;
    assign buf_active = r_buf_active;
    assign vblank     = (r_v_cnt >= V_ACT_L);
    assign vga_r      = r_pix;
    assign vga_g      = r_pix;
    assign vga_b      = r_pix;
    assign vga_hs     = r_hs;
    assign vga_vs     = r_vs;

endmodule

// File: tb/tb_vga_scanout_reader.sv
// Bench for vga_scanout_reader on a shrunken raster; reference model works from a linear clock count.
module tb_vga_scanout_reader;

    localparam int   HA  = 16;
    localparam int   HFP = 4;
    localparam int   HSY = 6;
    localparam int   HBP = 6;
    localparam int   VA  = 12;
    localparam int   VFP = 2;
    localparam int   VSY = 2;
    localparam int   VBP = 3;
    localparam int   HT  = HA + HFP + HSY + HBP;
    localparam int   VT  = VA + VFP + VSY + VBP;
    localparam int   F   = HT * VT;
    localparam logic SP  = 1'b0;

    logic        clk = 1'b0;
    logic        areset_n;
    logic        rd_en;
    logic [19:0] rd_addr;
    logic [3:0]  rd_data;
    logic        swap_req;
    logic        swap_ack;
    logic        buf_active;
    logic        vblank;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        vga_hs, vga_vs;

    always #5 clk = ~clk;

    vga_scanout_reader #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .CLK_DIV(2), .RD_LATENCY(1), .SYNC_POL(SP)
    ) dut (
        .clk(clk), .areset_n(areset_n),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .swap_req(swap_req), .swap_ack(swap_ack), .buf_active(buf_active),
        .vblank(vblank), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs)
    );

    logic [3:0] mem [0:127];

    int n_chk;
    int n_fail;
    int ack_seen;

    // Reference state: t = clock edges since reset release, pos = raster position in the frame.
    int          t;
    int          pos;
    logic        mbuf;
    logic        exp_en;
    logic [19:0] exp_addr;
    logic        exp_ack;
    logic [3:0]  exp_pix;
    logic        exp_hs, exp_vs, exp_vb;
    logic        rec_vld, rec_act, rec_hs, rec_vs;
    logic [3:0]  rec_dat;

    function automatic logic [3:0] ram_val(input logic [19:0] a);
        return mem[{a[19], a[5:0]}];
    endfunction

    task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        t = 0; pos = 0; mbuf = 1'b0;
        exp_en = 1'b0; exp_addr = '0; exp_ack = 1'b0;
        exp_pix = 4'h0; exp_hs = ~SP; exp_vs = ~SP; exp_vb = 1'b0;
        rec_vld = 1'b0; rec_act = 1'b0; rec_hs = ~SP; rec_vs = ~SP; rec_dat = 4'h0;
    endtask

    // Every second edge is a pixel edge; the pixel fetched there is shown two edges later.
    task automatic model_edge(input logic swp);
        int m, mx, my;
        t++;
        exp_en  = 1'b0;
        exp_ack = 1'b0;
        if (t % 2 == 0) begin
            if (rec_vld) begin
                exp_pix = rec_act ? rec_dat : 4'h0;
                exp_hs  = rec_hs;
                exp_vs  = rec_vs;
            end
            m  = (t / 2 - 1) % F;
            mx = m % HT;
            my = m / HT;
            exp_en = (mx < HA) && (my < VA);
            if (exp_en)
                exp_addr = {mbuf, 19'(my * HA + mx)};
            rec_vld = 1'b1;
            rec_act = exp_en;
            rec_dat = ram_val(exp_addr);
            rec_hs  = (mx >= HA + HFP && mx < HA + HFP + HSY) ? SP : ~SP;
            rec_vs  = (my >= VA + VFP && my < VA + VFP + VSY) ? SP : ~SP;
            if (m == VA * HT - 1 && swp) begin
                mbuf    = ~mbuf;
                exp_ack = 1'b1;
            end
        end
        pos    = (t / 2) % F;
        exp_vb = (pos / HT) >= VA;
    endtask

    task automatic check_all();
        chk("rd_en",      rd_en,      exp_en);
        chk("rd_addr",    rd_addr,    exp_addr);
        chk("swap_ack",   swap_ack,   exp_ack);
        chk("buf_active", buf_active, mbuf);
        chk("vblank",     vblank,     exp_vb);
        chk("vga_r",      vga_r,      exp_pix);
        chk("vga_g",      vga_g,      exp_pix);
        chk("vga_b",      vga_b,      exp_pix);
        chk("vga_hs",     vga_hs,     exp_hs);
        chk("vga_vs",     vga_vs,     exp_vs);
    endtask

    // One clock: RAM answers last cycle's read, model advances, outputs checked on the falling edge.
    task automatic step();
        logic        pe;
        logic [19:0] pa;
        logic        ps;
        pe = rd_en;
        pa = rd_addr;
        ps = swap_req;
        @(posedge clk);
        #1;
        if (!areset_n) begin
            rd_data = 4'($urandom);
            model_reset();
        end else begin
            if (pe)
                rd_data = ram_val(pa);
            model_edge(ps);
        end
        @(negedge clk);
        check_all();
        if (swap_ack === 1'b1)
            ack_seen++;
    endtask

    task automatic run_to(input int v, input int h);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (!(pos == v * HT + h && t % 2 == 0) && k < 2 * F + 8);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rd_en"},  rd_en,      1'b0);
        chk({tag, "_addr"},   rd_addr,    20'h0);
        chk({tag, "_ack"},    swap_ack,   1'b0);
        chk({tag, "_buf"},    buf_active, 1'b0);
        chk({tag, "_vblank"}, vblank,     1'b0);
        chk({tag, "_r"},      vga_r,      4'h0);
        chk({tag, "_g"},      vga_g,      4'h0);
        chk({tag, "_b"},      vga_b,      4'h0);
        chk({tag, "_hs"},     vga_hs,     1'b1);
        chk({tag, "_vs"},     vga_vs,     1'b1);
    endtask

    initial begin
        n_chk = 0; n_fail = 0; ack_seen = 0;
        for (int i = 0; i < 128; i++)
            mem[i] = 4'($urandom);
        areset_n = 1'b0;
        swap_req = 1'b0;
        rd_data  = 4'h0;
        model_reset();

        @(negedge clk);
        repeat (5) step();
        chk_reset_vals("reset_hold");

        areset_n = 1'b1;
        step();
        chk("pre_fetch_rd_en", rd_en, 1'b0);
        step();
        chk("first_fetch_rd_en", rd_en, 1'b1);
        chk("first_fetch_addr", rd_addr, 20'h0);

        // Swap requested mid-frame: taken once at the next vblank start.
        run_to(4, 0);
        swap_req = 1'b1;
        run_to(VA - 1, 0);
        chk("swap_not_early_buf", buf_active, 1'b0);
        chk("swap_not_early_ack", ack_seen, 0);
        run_to(VA, 1);
        chk("swap_ack_count_a", ack_seen, 1);
        chk("swap_buf_a", buf_active, 1'b1);
        swap_req = 1'b0;

        // No request at the following vblank: no toggle.
        run_to(4, 0);
        chk("buf1_fetch_addr_bit19", rd_addr[19], 1'b1);
        run_to(VA, 1);
        chk("swap_ack_count_b", ack_seen, 1);
        chk("swap_buf_b", buf_active, 1'b1);

        // Request held across two vblank starts: one toggle per frame.
        swap_req = 1'b1;
        run_to(VA, 1);
        run_to(VA, 1);
        chk("swap_ack_count_c", ack_seen, 3);
        chk("swap_buf_c", buf_active, 1'b1);
        swap_req = 1'b0;

        // Random swap requests over several frames.
        repeat (6 * F) begin
            swap_req = 1'($urandom);
            step();
        end
        swap_req = 1'b0;

        // Asynchronous reset in the middle of a visible line.
        run_to(7, 10);
        areset_n = 1'b0;
        #1;
        chk_reset_vals("midline_reset");
        repeat (3) step();
        areset_n = 1'b1;
        step();
        step();
        chk("post_reset_fetch_en", rd_en, 1'b1);
        chk("post_reset_fetch_addr", rd_addr, 20'h0);
        run_to(VA + 3, 0);
        run_to(2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
